// File: rtl/mux_pkg.sv
// Shared select encoding for the 8:1 selector family.
package mux_pkg;

    // Width of the select code {s1,s2,s3}.
    localparam int SEL_W = 3;

    // Select code for each data input; code n picks input i(n+1).
    localparam logic [SEL_W-1:0] SEL_I1 = 3'd0;
    localparam logic [SEL_W-1:0] SEL_I2 = 3'd1;
    localparam logic [SEL_W-1:0] SEL_I3 = 3'd2;
    localparam logic [SEL_W-1:0] SEL_I4 = 3'd3;
    localparam logic [SEL_W-1:0] SEL_I5 = 3'd4;
    localparam logic [SEL_W-1:0] SEL_I6 = 3'd5;
    localparam logic [SEL_W-1:0] SEL_I7 = 3'd6;
    localparam logic [SEL_W-1:0] SEL_I8 = 3'd7;

endpackage

// File: rtl/mux_8to1_core.sv
// Purely combinational 8:1 selector. The data bus is indexed by the select
// code directly, so every code is a valid choice and an X/Z select yields X
// in simulation instead of silently holding a stale value.
module mux_8to1_core
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [7:0][WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]      i_sel,
    output logic [WIDTH-1:0]      o_y
);

    assign o_y = i_data[i_sel];

endmodule

// File: rtl/mux_8to1.sv
// 8-input selector with a registered output: the input chosen by
// {s1,s2,s3} at a rising edge appears on y after that edge.
module mux_8to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    input  logic [WIDTH-1:0] i8,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    output logic [WIDTH-1:0] y
);

    logic [7:0][WIDTH-1:0] w_data;
    logic [SEL_W-1:0]      w_sel;
    logic [WIDTH-1:0]      w_sel_data;
    logic [WIDTH-1:0]      r_y;

    // s1 is the MSB of the select code.
    assign w_sel = {s1, s2, s3};

    // Place each input at the slot addressed by its select code.
    assign w_data[SEL_I1] = i1;
    assign w_data[SEL_I2] = i2;
    assign w_data[SEL_I3] = i3;
    assign w_data[SEL_I4] = i4;
    assign w_data[SEL_I5] = i5;
    assign w_data[SEL_I6] = i6;
    assign w_data[SEL_I7] = i7;
    assign w_data[SEL_I8] = i8;

    mux_8to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_data (w_data),
        .i_sel  (w_sel),
        .o_y    (w_sel_data)
    );

    // Output register: reset wins over any data/select activity on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= '0;
        end else begin
            r_y <= w_sel_data;
        end
    end

    assign y = r_y;

endmodule

// File: tb/tb_mux_8to1.sv
// Self-checking bench for mux_8to1 (WIDTH=8): a directed vector table,
// a hand-written mid-operation reset sequence, and randomized traffic
// checked against an array-indexing reference model.
module tb_mux_8to1;

    localparam int W = 8;

    typedef struct {
        string             name;
        logic              rst;
        logic [2:0]        sel;
        logic [7:0][W-1:0] d;
        logic [W-1:0]      exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i1, i2, i3, i4, i5, i6, i7, i8;
    logic         s1, s2, s3;
    logic [W-1:0] y;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mux_8to1 #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .i4  (i4),
        .i5  (i5),
        .i6  (i6),
        .i7  (i7),
        .i8  (i8),
        .s1  (s1),
        .s2  (s2),
        .s3  (s3),
        .y   (y)
    );

    function automatic void add_vec(input string n, input logic r,
                                    input logic [2:0] s,
                                    input logic [7:0][W-1:0] d,
                                    input logic [W-1:0] e);
        vec_t v;
        v.name = n;
        v.rst  = r;
        v.sel  = s;
        v.d    = d;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic [2:0] s,
                         input logic [7:0][W-1:0] d);
        rst = r;
        {s1, s2, s3} = s;
        i1 = d[0]; i2 = d[1]; i3 = d[2]; i4 = d[3];
        i5 = d[4]; i6 = d[5]; i7 = d[6]; i8 = d[7];
    endtask

    task automatic check(input string n, input logic [W-1:0] e);
        checks++;
        if (y !== e) begin
            failures++;
            $display("FAIL %s: y=%h expected=%h", n, y, e);
        end else begin
            $display("tx %s: y=%h expected=%h ok", n, y, e);
        end
    endtask

    // Drive one cycle's inputs, clock once, then sample y away from the edge.
    task automatic step(input string n, input logic r, input logic [2:0] s,
                        input logic [7:0][W-1:0] d, input logic [W-1:0] e);
        drive(r, s, d);
        @(posedge clk);
        #1;
        check(n, e);
    endtask

    initial begin
        logic [7:0][W-1:0] d;
        logic [W-1:0]      mdl [8];
        logic [2:0]        rs;
        logic              rr;

        // Reset: all inputs 1, sel 111, held for two edges.
        for (int i = 0; i < 8; i++) d[i] = 8'd1;
        add_vec("reset_edge1", 1'b1, 3'b111, d, 8'h00);
        add_vec("reset_edge2", 1'b1, 3'b111, d, 8'h00);

        // Select i8 with i1 and i8 set.
        d = '0; d[0] = 8'd1; d[7] = 8'd1;
        add_vec("sel_i8", 1'b0, 3'b111, d, 8'h01);

        // i8 cleared, i7 set: unselected i7 must not leak through.
        d = '0; d[6] = 8'd1;
        add_vec("sel_i8_cleared", 1'b0, 3'b111, d, 8'h00);

        // Exhaustive one-hot walk.
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 8; s++) begin
                d = '0; d[k] = 8'd1;
                add_vec($sformatf("walk_i%0d_sel%0d", k + 1, s), 1'b0,
                        3'(s), d, (s == k) ? 8'h01 : 8'h00);
            end
        end

        // Simultaneous select + data change.
        d = '0;
        add_vec("simul_pre0", 1'b0, 3'b000, d, 8'h00);
        d = '0; d[0] = 8'd1;
        add_vec("simul_pre1", 1'b0, 3'b000, d, 8'h01);
        d = '0; d[3] = 8'd1;
        add_vec("simul_change", 1'b0, 3'b011, d, 8'h01);

        foreach (vecs[i]) step(vecs[i].name, vecs[i].rst, vecs[i].sel,
                               vecs[i].d, vecs[i].exp);

        // Mid-operation reset with sel=101, i6=A5, others noisy.
        for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
        d[5] = 8'hA5;
        step("midrst_settle", 1'b0, 3'b101, d, 8'hA5);
        step("midrst_pulse", 1'b1, 3'b101, d, 8'h00);
        step("midrst_release", 1'b0, 3'b101, d, 8'hA5);

        // Randomized traffic against a reference model: y is the (sel+1)-th
        // input, or zero when reset is asserted.
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < 8; i++) begin
                mdl[i] = 8'($urandom);
                d[i]   = mdl[i];
            end
            rs = 3'($urandom_range(0, 7));
            rr = ($urandom_range(0, 15) == 0);
            step($sformatf("rand%0d_sel%0d_rst%0d", t, rs, rr), rr, rs, d,
                 rr ? 8'h00 : mdl[rs]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_8to1.md
Name: mux_8to1

Overview:
- 8-input, 1-output selector with a registered output, used wherever one of eight data sources is chosen by a 3-bit code.
- Select code {s1,s2,s3}, with s1 as MSB, picks one of i1..i8.
- The selected value is captured on the clock edge and driven on y.
- Leaf block with no handshaking; sits directly in datapath select logic.

Parameters:
- WIDTH, 1, bit width of each data input i1..i8 and of output y.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising clk edge.
- i1  input  WIDTH  data input, selected by code 000.
- i2  input  WIDTH  data input, selected by code 001.
- i3  input  WIDTH  data input, selected by code 010.
- i4  input  WIDTH  data input, selected by code 011.
- i5  input  WIDTH  data input, selected by code 100.
- i6  input  WIDTH  data input, selected by code 101.
- i7  input  WIDTH  data input, selected by code 110.
- i8  input  WIDTH  data input, selected by code 111.
- s1  input  1  select bit 2 (MSB).
- s2  input  1  select bit 1.
- s3  input  1  select bit 0 (LSB).
- y  output  WIDTH  registered selected data.

Behaviour:
- One clock, one synchronous active-high reset (rst); no asynchronous paths.
- Select code sel = {s1,s2,s3}; code n (0..7) selects input i(n+1).
  - Example: 111 selects i8; 000 selects i1.
- On each rising clk edge with rst=1: y <= 0 (all WIDTH bits). Reset value of y is 0.
- On each rising clk edge with rst=0: y <= input selected by the sel value sampled at that edge.
- Latency: exactly 1 cycle from inputs/select to y. No combinational path from any input to y.
- Data inputs and select are sampled together on the same edge. A select change and a data change on the same edge both take effect together in the next y.
- Unselected inputs have no effect on y, whatever their value.
- Select held constant, selected data changes: y follows the data one cycle later.
- rst asserted mid-operation: y goes to 0 at the next edge regardless of inputs. On the first edge after rst deasserts, y loads the selected input again.
- rst has priority over any data or select activity on the same edge.
- Before the first clk edge (power-up, no reset yet), y is undefined. Benches must apply rst first.
- All 8 codes are valid; there is no default or illegal-code case in synthesis.
  - For X/Z on select in simulation, y becomes X.
- No internal state other than the WIDTH-bit output register.

Decomposition:
- Shared package mux_pkg:
  - localparams SEL_I1..SEL_I8 = 3'd0..3'd7 for the select encoding.
  - Constant SEL_W = 3.
- Sub-module mux_8to1_core: purely combinational 8:1 selector, parameterised by WIDTH.
- mux_8to1 wraps mux_8to1_core with the reset-able output register.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with i1..i8 = 1 and sel=111.
  - Required: y=0 after the first edge, and y stays 0 while rst=1.
- Select i8:
  - Stimulus: rst=0, i1=1, i2..i7=0, i8=1, s1=s2=s3=1.
  - Required: y=1 one cycle later.
- Select i8 with i8 cleared:
  - Stimulus: change to i7=1, i8=0, others 0, sel still 111.
  - Required: y=0 on the next edge (i7 ignored).
- Exhaustive walk:
  - Stimulus: one-hot data with only i(k)=1, sweep sel over 000..111.
  - Required: y=1 exactly when sel = k-1, else 0, each result one cycle after its sel.
- Simultaneous change:
  - Stimulus: on one edge, sel 000->011 while i1 1->0 and i4 0->1.
  - Required: y=1 after that edge.
- Mid-operation reset (WIDTH=8):
  - Stimulus: sel=101, i6=8'hA5, y settled at 8'hA5; pulse rst for 1 cycle.
  - Required: y=8'h00 for that cycle, then y=8'hA5 one edge after rst drops.
